// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, mid-bit constant and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_e;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_MID_DEF        = UART_OVERSAMPLE_DEF / 2;

  function automatic int uart_mid(input int os);
    return os / 2;
  endfunction

  // Also used by the transmitter so both sides derive the same bit timing.
  function automatic int uart_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// rtl/uart_rx_baud_tick.sv - oversample tick divider with synchronous clear
module uart_rx_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q + CW'(1);
    if (clr_i || wrap) cnt_d = '0;
  end

  // A clear realigns the tick phase to the start edge, so it suppresses the tick.
  assign tick_o = wrap && !clr_i;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled 8N1 UART receiver with valid/ready output
// Optional even parity checking and rx_parity_err port with UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 1_843_200,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int M   = uart_mid(OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  uart_rx_state_e       state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                 stop_wait_q, stop_wait_d;
  logic                 drop_q, drop_d;
  logic                 par_err_q, par_err_d;
  logic                 start_edge, tick, vote, vote_now, load;

  assign start_edge = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
  assign vote_now   = tick && (s_q == SW'(M + 1));

  uart_rx_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_edge),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    bit_cnt_d   = bit_cnt_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    stop_wait_d = stop_wait_q;
    drop_d      = drop_q;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    load        = 1'b0;

    // s free-runs across the whole frame so state changes at the vote keep bit alignment.
    if (state_q != ST_IDLE && tick) begin
      s_d = (s_q == SW'(OVERSAMPLE - 1)) ? '0 : s_q + SW'(1);
      if (s_q == SW'(M - 1)) smp_d[0] = rxs_q;
      if (s_q == SW'(M))     smp_d[1] = rxs_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d     = ST_START;
          s_d         = '0;
          bit_cnt_d   = '0;
          stop_wait_d = 1'b0;
          drop_d      = 1'b0;
        end
      end
      ST_START: begin
        if (vote_now) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (vote_now) begin
          shift_d   = {vote, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (vote_now) begin
          if (vote != ^shift_q) begin
            par_err_d = 1'b1;
            drop_d    = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (stop_wait_q) begin
          if (rxs_q) begin
            state_d     = ST_IDLE;
            stop_wait_d = 1'b0;
          end
        end else if (vote_now) begin
          if (vote) begin
            load    = !drop_q;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            stop_wait_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_d    = load ? shift_q : data_q;
    valid_d   = load | (valid_q & !rx_ready);
    overrun_d = load & valid_q & !rx_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      s_q         <= '0;
      bit_cnt_q   <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      stop_wait_q <= 1'b0;
      drop_q      <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      s_q         <= s_d;
      bit_cnt_q   <= bit_cnt_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      stop_wait_q <= stop_wait_d;
      drop_q      <= drop_d;
      par_err_q   <= par_err_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != ST_IDLE);
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed vector bench for uart_rx_oversampled
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_frame_err, rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_oversampled dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  always @(negedge clk) begin
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_overrun)   ovr_cnt  <= ovr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each bit occupies 16 clocks, starting on a falling clock edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (15) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic has_par,
                            input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  int f0, o0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 0};
    vecs[6] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 0};

    repeat (3) @(negedge clk);
    check("reset_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_data", {24'b0, rx_data}, 32'd0);
    check("reset_busy", {31'b0, rx_busy}, 32'd0);
    check("reset_ferr", {31'b0, rx_frame_err}, 32'd0);
    check("reset_ovr", {31'b0, rx_overrun}, 32'd0);
    rst_n = 1'b1;
    idle_bits(1);

    for (int v = 0; v < 7; v++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      rx_ready = vecs[v].ready;
      send_frame(vecs[v].data, vecs[v].stop, 1'b0, 1'b0);
      idle_bits(2);
      rx_ready = 1'b0;
      check($sformatf("vec%0d_valid", v), {31'b0, rx_valid}, {31'b0, vecs[v].exp_valid});
      check($sformatf("vec%0d_data", v), {24'b0, rx_data}, {24'b0, vecs[v].exp_data});
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, 32'd0);
      check($sformatf("vec%0d_busy", v), {31'b0, rx_busy}, 32'd0);
      if (vecs[v].exp_valid) begin
        pulse_ready();
        check($sformatf("vec%0d_release", v), {31'b0, rx_valid}, 32'd0);
      end
    end

    // Short low glitch: start is rejected at the mid-bit vote.
    f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_hi", {31'b0, rx_busy}, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_busy_lo", {31'b0, rx_busy}, 32'd0);
    check("glitch_valid", {31'b0, rx_valid}, 32'd0);
    check("glitch_ferr", ferr_cnt - f0, 32'd0);

    // Back-to-back with nobody consuming: second byte overruns the first.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("b2b_ovr", ovr_cnt - o0, 32'd1);
    check("b2b_data", {24'b0, rx_data}, 32'h22);
    check("b2b_valid", {31'b0, rx_valid}, 32'd1);
    pulse_ready();

    // Back-to-back with rx_ready only in the cycle the second byte loads.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        repeat (156) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle_bits(1);
    check("b2b_rdy_ovr", ovr_cnt - o0, 32'd0);
    check("b2b_rdy_data", {24'b0, rx_data}, 32'h22);
    check("b2b_rdy_valid", {31'b0, rx_valid}, 32'd1);

    // Reset mid-DATA clears outputs and the partial frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    check("pre_rst_busy", {31'b0, rx_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_data", {24'b0, rx_data}, 32'd0);
    check("rst_busy", {31'b0, rx_busy}, 32'd0);
    idle_bits(10);
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("post_rst_data", {24'b0, rx_data}, 32'h81);
    check("post_rst_valid", {31'b0, rx_valid}, 32'd1);
    check("post_rst_ferr", ferr_cnt - f0, 32'd0);
    pulse_ready();

`ifdef UART_RX_PARITY_EN
    f0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle_bits(1);
    check("par_bad_err", perr_cnt - f0, 32'd1);
    check("par_bad_valid", {31'b0, rx_valid}, 32'd0);
    f0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check("par_ok_err", perr_cnt - f0, 32'd0);
    check("par_ok_data", {24'b0, rx_data}, 32'h07);
    check("par_ok_valid", {31'b0, rx_valid}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
